// File: rtl/sbox.sv
// AES forward S-box: purely combinational 256-entry byte substitution.
module sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  // Entry k sits in the byte at bits [(255-k)*8 +: 8]; row 0 holds entries 0x00..0x0f.
  localparam logic [2047:0] SboxTbl = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // ~in_i equals 255-in_i for an 8-bit index, selecting the byte from the MSB end.
  always_comb begin
    out_o = SboxTbl[{~in_i, 3'b000} +: 8];
  end

endmodule

// File: rtl/key_expand.sv
// AES-128 key schedule: presents round keys 0..10 one per handshake on a valid/ready stream.
module key_expand (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   rk_round,
  output logic [127:0] round_key,
  output logic         done
);

  localparam logic [3:0] LastRound = 4'd10;

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e        state_q, state_d;
  logic [127:0]  key_q, key_d;
  logic [3:0]    round_q, round_d;
  logic [7:0]    rcon_q, rcon_d;
  logic          done_q, done_d;

  logic [31:0]   w0, w1, w2, w3;
  logic [31:0]   rot_w3, sub_w3, t_word;
  logic [31:0]   nw0, nw1, nw2, nw3;
  logic [7:0]    rcon_next;

  // Split the current round key into its four words and rotate the last one.
  always_comb begin
    w0     = key_q[127:96];
    w1     = key_q[95:64];
    w2     = key_q[63:32];
    w3     = key_q[31:0];
    rot_w3 = {w3[23:0], w3[31:24]};
  end

  // SubWord: one S-box per byte of the rotated word.
  for (genvar g = 0; g < 4; g++) begin : g_subword
    sbox u_sbox (
      .in_i  (rot_w3[g*8 +: 8]),
      .out_o (sub_w3[g*8 +: 8])
    );
  end

  // Next round key: single-cycle XOR chain through all four words, plus rcon xtime.
  always_comb begin
    t_word    = sub_w3 ^ {rcon_q, 24'h000000};
    nw0       = w0 ^ t_word;
    nw1       = w1 ^ nw0;
    nw2       = w2 ^ nw1;
    nw3       = w3 ^ nw2;
    rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
  end

  // Next-state logic; all state holds unless an accepted start or handshake occurs.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StEmit;
          key_d   = key_in;
          round_d = 4'd0;
          rcon_d  = 8'h01;
        end
      end
      StEmit: begin
        if (rk_ready) begin
          if (round_q == LastRound) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            key_d   = {nw0, nw1, nw2, nw3};
            round_d = round_q + 4'd1;
            rcon_d  = rcon_next;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset that overrides start and handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      key_q   <= '0;
      round_q <= '0;
      rcon_q  <= 8'h01;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
      done_q  <= done_d;
    end
  end

  // Outputs come straight from registers; nothing depends combinationally on rk_ready.
  always_comb begin
    busy      = (state_q == StEmit);
    rk_valid  = (state_q == StEmit);
    rk_round  = round_q;
    round_key = key_q;
    done      = done_q;
  end

endmodule

// File: tb/tb_key_expand.sv
// Bench for key_expand: FIPS-197 style reference model built from GF(2^8) arithmetic.
module tb_key_expand;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [3:0]   rk_round;
  logic [127:0] round_key;
  logic         done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]   sb [256];
  logic [127:0] exp_rk [11];

  localparam logic [127:0] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  key_expand dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .busy      (busy),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_round  (rk_round),
    .round_key (round_key),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Textbook 44-word expansion; round r key is words 4r..4r+3.
  task automatic build_model(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h000000};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // mode 0: always ready; 1: 5-cycle stall at round 3 plus random ready;
  // 2: always ready with a foreign start pulsed during EMIT. lit1/lit10 = 0 skips them.
  task automatic run_seq(input logic [127:0] key, input int mode,
                         input logic [127:0] lit1, input logic [127:0] lit10);
    int   idx   = 0;
    int   stall = 0;
    int   cyc   = 0;
    logic r;
    build_model(key);
    start  = 1'b1;
    key_in = key;
    step();
    start  = 1'b0;
    key_in = rand_key();
    while (idx < 11 && cyc < 200) begin
      check("valid", 128'(rk_valid), 128'd1);
      check("busy", 128'(busy), 128'd1);
      check("done_low", 128'(done), 128'd0);
      check("rk_round", 128'(rk_round), 128'(idx));
      check("round_key", round_key, exp_rk[idx]);
      if (idx == 1 && lit1 != '0) check("fips_r1", round_key, lit1);
      if (idx == 10 && lit10 != '0) check("fips_r10", round_key, lit10);
      r = 1'b1;
      start = 1'b0;
      if (mode == 1) begin
        if (idx == 3 && stall < 5) begin
          r = 1'b0;
          stall++;
        end else begin
          r = 1'($urandom_range(0, 1));
        end
      end else if (mode == 2 && idx == 4) begin
        start  = 1'b1;
        key_in = rand_key();
      end
      rk_ready = r;
      if (r) idx++;
      step();
      cyc++;
    end
    start = 1'b0;
    check("handshakes", 128'(idx), 128'd11);
    if (mode != 1) check("latency", 128'(cyc), 128'd11);
    check("done_pulse", 128'(done), 128'd1);
    check("busy_end", 128'(busy), 128'd0);
    check("valid_end", 128'(rk_valid), 128'd0);
    rk_ready = 1'b0;
    step();
    check("done_once", 128'(done), 128'd0);
  endtask

  initial begin
    logic [127:0] k;
    rst      = 1'b1;
    start    = 1'b0;
    key_in   = '0;
    rk_ready = 1'b0;
    build_sbox();
    step();
    step();
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_valid", 128'(rk_valid), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_round", 128'(rk_round), 128'd0);
    check("rst_key", round_key, 128'd0);
    rst = 1'b0;
    step();
    check("idle_busy", 128'(busy), 128'd0);

    run_seq(FipsKey, 0, 128'ha0fafe1788542cb123a339392a6c7605,
            128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run_seq(128'd0, 0, 128'h62636363626363636263636362636363,
            128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    run_seq(FipsKey, 1, 128'd0, 128'd0);
    run_seq(rand_key(), 2, 128'd0, 128'd0);

    // Reset in the middle of an expansion abandons it without a done pulse.
    k = rand_key();
    build_model(k);
    start    = 1'b1;
    key_in   = k;
    rk_ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("mid_round", 128'(rk_round), 128'd5);
    check("mid_key", round_key, exp_rk[5]);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_busy", 128'(busy), 128'd0);
    check("mrst_valid", 128'(rk_valid), 128'd0);
    check("mrst_round", 128'(rk_round), 128'd0);
    check("mrst_key", round_key, 128'd0);
    check("mrst_done", 128'(done), 128'd0);
    step();
    check("mrst_done2", 128'(done), 128'd0);
    run_seq(rand_key(), 0, 128'd0, 128'd0);

    // Back-to-back: start held high restarts in the done cycle.
    build_model(FipsKey);
    start    = 1'b1;
    key_in   = FipsKey;
    rk_ready = 1'b1;
    step();
    for (int r = 0; r < 11; r++) begin
      check("b2b_round", 128'(rk_round), 128'(r));
      check("b2b_key", round_key, exp_rk[r]);
      step();
    end
    check("b2b_done", 128'(done), 128'd1);
    check("b2b_busy", 128'(busy), 128'd0);
    step();
    start = 1'b0;
    check("b2b_restart_valid", 128'(rk_valid), 128'd1);
    check("b2b_restart_round", 128'(rk_round), 128'd0);
    check("b2b_restart_key", round_key, FipsKey);
    check("b2b_done_low", 128'(done), 128'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
